// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Built with or without FETCH_PERF_CNT_EN; see fetch_controller.
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} buffer between the ROM and decode; flush wins over push/pop.
// The head output holds its last presented value while the buffer is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_data,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);
  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  hold_q;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      hold_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Track what decode last saw so the outputs stay stable once drained.
      if (count_q != '0) hold_q <= mem[rd_ptr];
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (!push && pop) count_q <= count_q - CW'(1);
      end
    end
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem[rd_ptr] : hold_q;
endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fetches from a combinational ROM, buffers for decode.
// FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic                     fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic                     fetch_err_q;
  logic [CW-1:0]            fifo_count;
  fetch_entry_t             fifo_head;
  fetch_entry_t             fifo_in;
  logic                     push;
  logic                     pop;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  // A full buffer can still accept when the head leaves this cycle.
  assign push      = ~halt & ~redirect_valid & ((fifo_count < CW'(DEPTH)) | pop);

  assign fifo_in.pc    = 32'(pc_q);
  assign fifo_in.instr = 32'(imem_instr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) pc_q <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      else if (push)      pc_q <= pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (fifo_in),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_addr = pc_q;
  assign out_pc    = ADDRESS_WIDTH'(fifo_head.pc);
  assign out_instr = DATA_WIDTH'(fifo_head.instr);
  assign fetch_err = fetch_err_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)                   perf_fetched <= perf_fetched + 32'd1;
      if (out_valid & ~out_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: scoreboard of expected PCs consumed on each handshake.
// A second instance uses a near-top RESET_PC to exercise PC wrap.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_pc, out_instr;
  logic        halt = 1'b0, redirect_valid = 1'b0, out_valid, out_ready = 1'b0, fetch_err;
  logic [31:0] w_imem_addr, w_imem_instr, w_out_pc, w_out_instr;
  logic        w_out_valid, w_fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  int tests_run = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h13 + {a[26:2], 7'b0};
  endfunction

  assign imem_instr   = rom(imem_addr);
  assign w_imem_instr = rom(w_imem_addr);

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_err(fetch_err)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .halt(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc),
    .out_instr(w_out_instr), .fetch_err(w_fetch_err)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Score the handshake that the coming edge completes, then advance one cycle.
  task automatic tick();
    logic [31:0] e;
    if (out_valid && out_ready && !redirect_valid) begin
      tests_run++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL spurious_beat: observed pc %h expected no beat", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_pc", out_pc, e);
        check("beat_instr", out_instr, rom(e));
      end
    end
    if (redirect_valid) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beats(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w_exp [3];
    w_exp[0] = 32'hFFFF_FFF8;
    w_exp[1] = 32'hFFFF_FFFC;
    w_exp[2] = 32'h0000_0000;
    redirect_pc = 32'h0;

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);

    // 1: streaming with out_ready=1, no bubbles; wrap instance alongside
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", {31'b0, out_valid}, 32'd1);
      if (i < 3) begin
        check("wrap_pc", w_out_pc, w_exp[i]);
        check("wrap_instr", w_out_instr, rom(w_exp[i]));
      end
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream
    #2 rst_n = 1'b0;
    out_ready = 1'b0;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_pc", out_pc, 32'd0);
    check("midrst_imem_addr", imem_addr, 32'd0);
    check("midrst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: backpressure fills the buffer, then release
    for (int i = 0; i < 5; i++) tick();
    check("full_imem_addr", imem_addr, 32'h8);
    check("full_valid", {31'b0, out_valid}, 32'd1);
    check("full_head_pc", out_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd2);
    check("perf_stall", perf_stall, 32'd4);
`endif
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    out_ready = 1'b1;
    run_beats(20);

    // 3: redirect while full
    out_ready = 1'b0;
    tick(); tick();
    check("pre_redir_valid", {31'b0, out_valid}, 32'd1);
    redirect_pc = 32'h40;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_bubble", {31'b0, out_valid}, 32'd0);
    check("redir_imem_addr", imem_addr, 32'h40);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    out_ready = 1'b1;
    tick();
    check("redir_target_valid", {31'b0, out_valid}, 32'd1);
    check("redir_target_pc", out_pc, 32'h40);
    run_beats(10);

    // 4: misaligned redirect
    redirect_pc = 32'h46;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("misalign_err", {31'b0, fetch_err}, 32'd1);
    check("misalign_bubble", {31'b0, out_valid}, 32'd0);
    exp_q.push_back(32'h44);
    tick();
    check("misalign_err_clr", {31'b0, fetch_err}, 32'd0);
    check("misalign_pc", out_pc, 32'h44);
    run_beats(10);

    // 5: halt drains the buffer and holds the PC
    out_ready = 1'b0;
    redirect_pc = 32'h8;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    check("halt_pre_addr", imem_addr, 32'h10);
    halt = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_imem_addr", imem_addr, 32'h10);
    end
    check("halt_drained_valid", {31'b0, out_valid}, 32'd0);
    check("halt_drained_sb", 32'(exp_q.size()), 32'd0);
    halt = 1'b0;
    exp_q.push_back(32'h10);
    tick();
    check("resume_pc", out_pc, 32'h10);
    run_beats(10);

    // Redirect during halt
    halt = 1'b1;
    redirect_pc = 32'h80;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("halt_redir_addr", imem_addr, 32'h80);
    check("halt_redir_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("halt_redir_hold", imem_addr, 32'h80);
    halt = 1'b0;
    exp_q.push_back(32'h80); exp_q.push_back(32'h84);
    run_beats(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
